decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and immediate width (from rapid_pkg).
REQ-002 SHALL have parameter DEPTH, default 4: instruction-buffer entries; power of two, at least 2.
REQ-003 SHALL have parameter ENABLE_M, default 0: when 1, the RV32M encodings are legal.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: ports i_clk and i_rst_n.
REQ-005 SHALL have ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  discard all buffered and output instructions.
- i_valid  in  1  fetch offers an instruction.
- o_ready  out  1  stage can accept.
- i_instruction  in  32  raw instruction.
- i_pc  in  XLEN  instruction PC.
- o_valid  out  1  decoded packet valid.
- i_ready  in  1  execute accepts the packet.
- o_control_signal  out  control_ex_s  decoded controls.
- o_imm  out  XLEN  sign-extended immediate.
- o_pc  out  XLEN  PC of the packet.
- o_illegal  out  1  packet is an illegal instruction.
- o_count  out  $clog2(DEPTH)+1  buffer occupancy.

Function
REQ-006 SHALL push {i_instruction, i_pc} into a circular FIFO when i_valid && o_ready.
REQ-007 SHALL drive o_ready = (count != DEPTH) && !i_flush; no same-cycle bypass when full.
REQ-008 SHALL load the output register from the FIFO head when the FIFO is non-empty and (!o_valid || i_ready).
REQ-009 SHALL complete a packet on o_valid && i_ready; o_valid and all packet outputs SHALL hold stable while o_valid && !i_ready.
REQ-010 SHALL give latency of exactly 2 cycles from the accepting edge to o_valid when empty and unstalled.
REQ-011 SHALL sustain throughput of 1 packet per cycle.
REQ-012 SHALL handle simultaneous push and pop by leaving the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-013 SHALL decode opcode families as follows:
- LUI and AUIPC: load_upper_imm.
- JAL and JALR: uncond_branch.
- Branches: cond_branch.
- Loads and stores: mem.
- OP-IMM: alu_imm.
- OP: alu_reg.
- rs/rd fields and fcs_opcode = instr[14:12] SHALL be set as in the predecessor single-cycle decoder.
REQ-014 SHALL assign the immediate in every case; R-type and illegal encodings SHALL give o_imm = 0.
REQ-015 SHALL sign-extend all immediates from bit 31 to XLEN.
REQ-016 SHALL flag o_illegal = 1 for any of:
- instr[1:0] != 2'b11;
- an unlisted opcode;
- OP funct7 other than 0000000 or 0100000, unless ENABLE_M and funct7 == 0000001;
- SLLI/SRLI/SRAI with an invalid funct7.
REQ-017 SHALL output control_ex_s_default() with rd = rs1 = rs2 = 0 for an illegal packet, still carrying debug_instruction and o_pc.
REQ-018 SHALL, on i_flush, next cycle set count = 0, pointers = 0 and o_valid = 0; a push offered in the flush cycle SHALL be dropped.
REQ-019 SHALL give i_flush priority over push, pop and output load.

Reset
REQ-020 SHALL, while i_rst_n is low, asynchronously force:
- o_valid = 0, o_illegal = 0, o_count = 0;
- FIFO pointers = 0;
- o_control_signal = control_ex_s_default();
- o_imm = 0, o_pc = 0.
REQ-021 SHALL drive o_ready = 0 while reset is asserted; o_ready SHALL be 1 in the first cycle after release.
REQ-022 SHALL discard all buffered and output contents when reset is asserted mid-operation.

Structure
REQ-023 SHALL define the opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP) in rapid_pkg, not as file-scope localparams.
REQ-024 SHALL define the FIFO entry typedef fetch_entry_s {instr, pc} in rapid_pkg.
REQ-025 SHALL place pure combinational decode in one sub-module, rv_decode_comb (instr -> control, imm, illegal).
REQ-026 SHALL keep the FIFO and the output register in decode_stage.

Verification
REQ-027 SHALL cover: 0x00500093 (ADDI x1,x0,5), empty stage -> o_valid 2 cycles later, alu_imm=1, rd=1, rs1=0, rs1_out=1, o_imm=0x00000005, o_illegal=0.
REQ-028 SHALL cover: 0xFE000EE3 (BEQ x0,x0,-4) -> cond_branch=1, rs1_out=rs2_out=1, o_imm=0xFFFFFFFC.
REQ-029 SHALL cover: DEPTH=4, i_ready=0, i_valid held high -> exactly 5 accepted, o_ready=0, o_count=4; then i_ready=1 -> 5 packets drained in order, one per cycle.
REQ-030 SHALL cover: 0x022081B3 (MUL x3,x1,x2) -> o_illegal=1 with ENABLE_M=0; alu_reg=1, rd=3, o_illegal=0 with ENABLE_M=1.
REQ-031 SHALL cover: 3 buffered entries plus an output packet, i_flush for 1 cycle with i_valid=1 -> next cycle o_valid=0, o_count=0, the flushed-cycle instruction never appears.
REQ-032 SHALL cover: i_rst_n pulsed low mid-stream (async, between edges) -> outputs zero immediately; first post-reset instruction decodes with 2-cycle latency.

Source files
------------

// File: rtl/rapid_pkg.sv
// Shared decode types and RV32 opcode constants for the rapid pipeline.
package rapid_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } instr_fmt_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_s;

    typedef struct packed {
        logic        load_upper_imm;
        logic        uncond_branch;
        logic        cond_branch;
        logic        mem;
        logic        alu_imm;
        logic        alu_reg;
        logic        rs1_out;
        logic        rs2_out;
        logic [2:0]  fcs_opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] debug_instruction;
    } control_ex_s;

    function automatic control_ex_s control_ex_s_default();
        return '0;
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I(M) decoder: raw instruction -> controls, immediate, illegal flag.
module rv_decode_comb
    import rapid_pkg::*;
#(
    parameter int unsigned XLEN     = rapid_pkg::XLEN,
    parameter bit          ENABLE_M = 1'b0
) (
    input  logic [31:0]     instr,
    output control_ex_s     control,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    instr_fmt_e  fmt;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign funct7 = instr[31:25];
    assign funct3 = instr[14:12];

    always_comb begin
        fmt     = FMT_X;
        control = control_ex_s_default();
        illegal = 1'b0;
        imm32   = '0;
        imm     = '0;

        unique case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                control.load_upper_imm = 1'b1;
            end
            OPC_JAL: begin
                fmt = FMT_J;
                control.uncond_branch = 1'b1;
            end
            OPC_JALR: begin
                fmt = FMT_I;
                control.uncond_branch = 1'b1;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                control.cond_branch = 1'b1;
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                control.mem = 1'b1;
            end
            OPC_STORE: begin
                fmt = FMT_S;
                control.mem = 1'b1;
            end
            OPC_OPIMM: begin
                fmt = FMT_I;
                control.alu_imm = 1'b1;
                if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
            end
            OPC_OP: begin
                fmt = FMT_R;
                control.alu_reg = 1'b1;
                if (!(funct7 == 7'b0000000 || funct7 == 7'b0100000 ||
                      (ENABLE_M && funct7 == 7'b0000001))) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (instr[1:0] != 2'b11) illegal = 1'b1;

        unique case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        control.rd      = (fmt inside {FMT_U, FMT_J, FMT_I, FMT_R}) ? instr[11:7]  : 5'd0;
        control.rs1     = (fmt inside {FMT_I, FMT_S, FMT_B, FMT_R}) ? instr[19:15] : 5'd0;
        control.rs2     = (fmt inside {FMT_S, FMT_B, FMT_R})        ? instr[24:20] : 5'd0;
        control.rs1_out = fmt inside {FMT_I, FMT_S, FMT_B, FMT_R};
        control.rs2_out = fmt inside {FMT_S, FMT_B, FMT_R};
        control.fcs_opcode        = funct3;
        control.debug_instruction = instr;
        imm = XLEN'($signed(imm32));

        // Illegal packets carry only the raw word for debug; everything else reverts to default.
        if (illegal) begin
            control = control_ex_s_default();
            control.debug_instruction = instr;
            imm = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction FIFO from fetch, combinational decode of the head, registered output packet.
module decode_stage
    import rapid_pkg::*;
#(
    parameter int unsigned XLEN     = rapid_pkg::XLEN,
    parameter int unsigned DEPTH    = 4,
    parameter bit          ENABLE_M = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [31:0]            i_instruction,
    input  logic [XLEN-1:0]        i_pc,
    output logic                   o_valid,
    input  logic                   i_ready,
    output control_ex_s            o_control_signal,
    output logic [XLEN-1:0]        o_imm,
    output logic [XLEN-1:0]        o_pc,
    output logic                   o_illegal,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_s    fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    fetch_entry_s    head;
    control_ex_s     dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    assign o_ready = i_rst_n && (count != CW'(DEPTH)) && !i_flush;
    assign push    = i_valid && o_ready;
    assign pop     = (count != '0) && (!o_valid || i_ready) && !i_flush;
    assign head    = fifo_mem[rd_ptr];
    assign o_count = count;

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= '{instr: i_instruction, pc: i_pc};
    end

    // DEPTH is a power of two, so pointer wrap is the natural PW-bit overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    rv_decode_comb #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr   (head.instr),
        .control (dec_ctrl),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid          <= 1'b0;
            o_illegal        <= 1'b0;
            o_control_signal <= control_ex_s_default();
            o_imm            <= '0;
            o_pc             <= '0;
        end else if (i_flush) begin
            o_valid   <= 1'b0;
            o_illegal <= 1'b0;
        end else if (pop) begin
            o_valid          <= 1'b1;
            o_control_signal <= dec_ctrl;
            o_imm            <= dec_imm;
            o_pc             <= head.pc;
            o_illegal        <= dec_illegal;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage, run on an ENABLE_M=0 and an ENABLE_M=1 instance in lockstep.
module tb_decode_stage;
    import rapid_pkg::*;

    typedef struct {
        control_ex_s ctrl;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;

    logic        rdy0, vld0, ill0, rdy1, vld1, ill1;
    control_ex_s ctl0, ctl1;
    logic [31:0] imm0, pco0, imm1, pco1;
    logic [2:0]  cnt0, cnt1;

    int   checks = 0;
    int   errors = 0;
    pkt_t q0[$];
    pkt_t q1[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .DEPTH(4), .ENABLE_M(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy0),
        .i_instruction(instr), .i_pc(pc), .o_valid(vld0), .i_ready(ready),
        .o_control_signal(ctl0), .o_imm(imm0), .o_pc(pco0), .o_illegal(ill0), .o_count(cnt0)
    );

    decode_stage #(.XLEN(32), .DEPTH(4), .ENABLE_M(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(rdy1),
        .i_instruction(instr), .i_pc(pc), .o_valid(vld1), .i_ready(ready),
        .o_control_signal(ctl1), .o_imm(imm1), .o_pc(pco1), .o_illegal(ill1), .o_count(cnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA rules: family, register usage, arithmetic immediate.
    function automatic pkt_t model(input logic [31:0] ins, input logic [31:0] ipc, input bit en_m);
        pkt_t        p;
        logic [31:0] v;
        logic [6:0]  f7;
        logic [2:0]  f3;
        bit          wrd, r1, r2, bad;
        f7 = ins[31:25];
        f3 = ins[14:12];
        p.ctrl = '0;
        p.pc = ipc;
        v = 32'd0;
        wrd = 0; r1 = 0; r2 = 0;
        bad = (ins[1:0] != 2'b11);
        case (ins[6:0])
            OPC_LUI, OPC_AUIPC: begin p.ctrl.load_upper_imm = 1; wrd = 1; v = ins & 32'hFFFF_F000; end
            OPC_JAL: begin
                p.ctrl.uncond_branch = 1; wrd = 1;
                v = 32'(ins[30:21]) * 2 + 32'(ins[20]) * 2048 + 32'(ins[19:12]) * 4096 - 32'(ins[31]) * 32'h0010_0000;
            end
            OPC_JALR:  begin p.ctrl.uncond_branch = 1; wrd = 1; r1 = 1; v = $signed(ins) >>> 20; end
            OPC_BRANCH: begin
                p.ctrl.cond_branch = 1; r1 = 1; r2 = 1;
                v = 32'(ins[11:8]) * 2 + 32'(ins[30:25]) * 32 + 32'(ins[7]) * 2048 - 32'(ins[31]) * 4096;
            end
            OPC_LOAD:  begin p.ctrl.mem = 1; wrd = 1; r1 = 1; v = $signed(ins) >>> 20; end
            OPC_STORE: begin
                p.ctrl.mem = 1; r1 = 1; r2 = 1;
                v = 32'(ins[11:7]) + 32'(ins[30:25]) * 32 - 32'(ins[31]) * 2048;
            end
            OPC_OPIMM: begin
                p.ctrl.alu_imm = 1; wrd = 1; r1 = 1; v = $signed(ins) >>> 20;
                if (f3 == 3'd1 && f7 != 7'd0) bad = 1;
                if (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'd32) bad = 1;
            end
            OPC_OP: begin
                p.ctrl.alu_reg = 1; wrd = 1; r1 = 1; r2 = 1;
                if (!(f7 == 7'd0 || f7 == 7'd32 || (en_m && f7 == 7'd1))) bad = 1;
            end
            default: bad = 1;
        endcase
        if (bad) begin
            p.ctrl = '0;
            p.ctrl.debug_instruction = ins;
            p.imm = 32'd0;
            p.illegal = 1'b1;
        end else begin
            p.ctrl.rd  = wrd ? ins[11:7]  : 5'd0;
            p.ctrl.rs1 = r1  ? ins[19:15] : 5'd0;
            p.ctrl.rs2 = r2  ? ins[24:20] : 5'd0;
            p.ctrl.rs1_out = r1;
            p.ctrl.rs2_out = r2;
            p.ctrl.fcs_opcode = f3;
            p.ctrl.debug_instruction = ins;
            p.imm = v;
            p.illegal = 1'b0;
        end
        return p;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [9] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                  OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP};
        logic [6:0]  f7s [4] = '{7'd0, 7'd32, 7'd1, 7'd5};
        logic [31:0] w;
        int unsigned k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) begin
            w[6:0] = opcs[k];
            if ((k == 7 && $urandom_range(0, 1) == 1) || k == 8) w[31:25] = f7s[$urandom_range(0, 3)];
        end
        return w;
    endfunction

    // One cycle of stimulus: drive at posedge+1, record acceptance at posedge+8, return at next posedge+1.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy, input logic fl, output logic acc);
        valid = v;
        instr = ins;
        ready = rdy;
        flush = fl;
        #7;
        acc = v && rdy0;
        if (v && rdy0) q0.push_back(model(ins, pc, 1'b0));
        if (v && rdy1) q1.push_back(model(ins, pc, 1'b1));
        @(posedge clk);
        #1;
        if (acc) pc = pc + 32'd4;
    endtask

    // Monitor: compare each presented packet with the scoreboard head; pop on completion.
    logic post_flush = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (post_flush) begin
                chk("flush_valid", 64'(vld0), 64'd0);
                chk("flush_count", 64'(cnt0), 64'd0);
            end
            chk("count0", 64'(cnt0) + 64'(vld0), 64'(q0.size()));
            chk("count1", 64'(cnt1) + 64'(vld1), 64'(q1.size()));
            if (vld0) begin
                if (q0.size() == 0) chk("unexpected0", 64'(ctl0.debug_instruction), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    chk("ctrl0", 64'(ctl0), 64'(q0[0].ctrl));
                    chk("imm0", 64'(imm0), 64'(q0[0].imm));
                    chk("pc0", 64'(pco0), 64'(q0[0].pc));
                    chk("illegal0", 64'(ill0), 64'(q0[0].illegal));
                    if (ready && !flush) void'(q0.pop_front());
                end
            end
            if (vld1) begin
                if (q1.size() == 0) chk("unexpected1", 64'(ctl1.debug_instruction), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    chk("ctrl1", 64'(ctl1), 64'(q1[0].ctrl));
                    chk("imm1", 64'(imm1), 64'(q1[0].imm));
                    chk("pc1", 64'(pco1), 64'(q1[0].pc));
                    chk("illegal1", 64'(ill1), 64'(q1[0].illegal));
                    if (ready && !flush) void'(q1.pop_front());
                end
            end
            if (flush) begin
                q0.delete();
                q1.delete();
            end
            post_flush <= flush;
        end else begin
            post_flush <= 1'b0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(vld0), 64'd0);
        chk({tag, "_count"}, 64'(cnt0), 64'd0);
        chk({tag, "_ready"}, 64'(rdy0), 64'd0);
        chk({tag, "_imm"}, 64'(imm0), 64'd0);
        chk({tag, "_pc"}, 64'(pco0), 64'd0);
        chk({tag, "_illegal"}, 64'(ill0), 64'd0);
        chk({tag, "_ctrl"}, 64'(ctl0), 64'd0);
    endtask

    // Present one instruction to an idle stage; o_valid must be low after the accepting edge, high after the next.
    task automatic latency(input logic [31:0] ins, input string tag);
        logic acc;
        cyc(1'b1, ins, 1'b1, 1'b0, acc);
        chk({tag, "_accept"}, 64'(acc), 64'd1);
        chk({tag, "_valid_early"}, 64'(vld0), 64'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);
        chk({tag, "_valid_lat2"}, 64'(vld0), 64'd1);
    endtask

    initial begin
        logic acc;
        int   n;
        #1;
        chk_reset_outputs("reset");
        #21;
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", 64'(rdy0), 64'd1);
        @(posedge clk);
        #1;

        latency(32'h0050_0093, "addi");
        chk("addi_alu_imm", 64'(ctl0.alu_imm), 64'd1);
        chk("addi_rd", 64'(ctl0.rd), 64'd1);
        chk("addi_rs1", 64'(ctl0.rs1), 64'd0);
        chk("addi_rs1_out", 64'(ctl0.rs1_out), 64'd1);
        chk("addi_imm", 64'(imm0), 64'h0000_0005);
        chk("addi_illegal", 64'(ill0), 64'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);

        latency(32'hFE00_0EE3, "beq");
        chk("beq_cond", 64'(ctl0.cond_branch), 64'd1);
        chk("beq_rs1_out", 64'(ctl0.rs1_out), 64'd1);
        chk("beq_rs2_out", 64'(ctl0.rs2_out), 64'd1);
        chk("beq_imm", 64'(imm0), 64'hFFFF_FFFC);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);

        latency(32'h0220_81B3, "mul");
        chk("mul_illegal_m0", 64'(ill0), 64'd1);
        chk("mul_alu_reg_m1", 64'(ctl1.alu_reg), 64'd1);
        chk("mul_rd_m1", 64'(ctl1.rd), 64'd3);
        chk("mul_illegal_m1", 64'(ill1), 64'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);

        n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, rand_instr(), 1'b0, 1'b0, acc);
            if (acc) n++;
        end
        chk("full_accepted", 64'(n), 64'd5);
        chk("full_ready", 64'(rdy0), 64'd0);
        chk("full_count", 64'(cnt0), 64'd4);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);
        chk("drain_empty", 64'(q0.size()), 64'd0);
        chk("drain_valid", 64'(vld0), 64'd0);

        for (int i = 0; i < 4; i++) cyc(1'b1, rand_instr(), 1'b0, 1'b0, acc);
        chk("preflush_count", 64'(cnt0), 64'd3);
        chk("preflush_valid", 64'(vld0), 64'd1);
        cyc(1'b1, 32'h00A0_0513, 1'b0, 1'b1, acc);
        chk("flush_drop", 64'(acc), 64'd0);
        chk("postflush_valid", 64'(vld0), 64'd0);
        chk("postflush_count", 64'(cnt0), 64'd0);

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 9) < 7), rand_instr(), 1'($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 99) < 3), acc);

        for (int i = 0; i < 3; i++) cyc(1'b1, rand_instr(), 1'b0, 1'b0, acc);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk_reset_outputs("midreset");
        #2;
        rst_n = 1'b1;
        #1;
        chk("midreset_ready_release", 64'(rdy0), 64'd1);
        @(posedge clk);
        #1;
        latency(32'h0050_0093, "post_reset");
        chk("post_reset_imm", 64'(imm0), 64'h0000_0005);

        for (int i = 0; i < 200; i++)
            cyc(1'($urandom_range(0, 1)), rand_instr(), 1'($urandom_range(0, 3) != 0), 1'b0, acc);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);
            n++;
        end
        chk("final_drain0", 64'(q0.size()), 64'd0);
        chk("final_drain1", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
